uart_frame_loader: RTL and testbench



---
 rtl/uart_frame_loader_if.sv | 27 ++
 rtl/uart_frame_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_if.sv
// Bundles the serial input and the committed-frame outputs of uart_frame_loader.
// The master side drives uart_rx; the slave side is the loader itself.
interface uart_frame_loader_if #(
    parameter int N_CELLS = 20
) ();
    logic                   uart_rx;
    logic [32*N_CELLS-1:0]  u_out;
    logic                   load_valid;
    logic                   busy;
    logic                   err;

    modport master (
        output uart_rx,
        input  u_out,
        input  load_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  uart_rx,
        output u_out,
        output load_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/uart_frame_loader.sv
// UART initial-condition frame loader: 8N1 receiver, header-hunting parser, inter-byte
// timeout and shadow/commit register. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module uart_frame_loader #(
    parameter int         DELAY_FRAMES = 234,
    parameter int         N_CELLS      = 20,
    parameter logic [7:0] HDR_BYTE     = 8'h01,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_frame_loader_if.slave bus
);
    localparam int N_BYTES  = 4 * N_CELLS;
    localparam int CNT_W    = $clog2(DELAY_FRAMES + 1);
    localparam int IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * (DELAY_FRAMES + 1);
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DELAY_FRAMES / 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} p_state_t;
`else
    typedef enum logic [0:0] {P_HUNT, P_PAYLOAD} p_state_t;
`endif

    logic                  sync1_q, sync2_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  frame_err_q, frame_err_d;

    p_state_t              p_state_q, p_state_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [32*N_CELLS-1:0] shadow_q, shadow_d;
    logic [32*N_CELLS-1:0] u_out_q, u_out_d;
    logic                  load_valid_q, load_valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [TO_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic                  commit;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xsum_q, xsum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.uart_rx;
            sync2_q <= sync1_q;
        end
    end

    // A start bit is re-checked at mid-bit so short low glitches are rejected.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_CNT) begin
                    rx_cnt_d   = '0;
                    bit_idx_d  = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_CNT) begin
                    rx_cnt_d  = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == FULL_CNT) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = sync2_q;
                    frame_err_d  = !sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // The idle counter holds cycles since the last byte, so a byte arriving on the timeout cycle wins.
    always_comb begin
        p_state_d    = p_state_q;
        hdr_cnt_d    = hdr_cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        u_out_d      = u_out_q;
        load_valid_d = 1'b0;
        err_d        = 1'b0;
        commit       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xsum_d       = xsum_q;
`endif
        if (byte_valid_q) begin
            idle_cnt_d = TO_W'(1);
        end else if (!busy_q) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (frame_err_q) begin
            p_state_d = P_HUNT;
            hdr_cnt_d = '0;
            err_d     = 1'b1;
        end else if (byte_valid_q) begin
            unique case (p_state_q)
                P_HUNT: begin
                    if (shift_q == HDR_BYTE) begin
                        if (hdr_cnt_q == 2'd3) begin
                            p_state_d = P_PAYLOAD;
                            hdr_cnt_d = '0;
                            idx_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                            xsum_d    = '0;
`endif
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 2'd1;
                        end
                    end else begin
                        hdr_cnt_d = '0;
                    end
                end
                P_PAYLOAD: begin
                    shadow_d[{idx_q, 3'b000} +: 8] = shift_q;
                    idx_d = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xsum_d = xsum_q ^ shift_q;
                    if (idx_q == LAST_IDX) begin
                        p_state_d = P_CHECK;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        commit = 1'b1;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                P_CHECK: begin
                    if (shift_q == xsum_q) begin
                        commit = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    p_state_d = P_HUNT;
                end
`endif
                default: p_state_d = P_HUNT;
            endcase
        end else if (busy_q && (idle_cnt_q == TO_LAST)) begin
            p_state_d = P_HUNT;
            hdr_cnt_d = '0;
            err_d     = 1'b1;
        end

        if (commit) begin
            u_out_d      = shadow_d;
            load_valid_d = 1'b1;
            p_state_d    = P_HUNT;
        end
        busy_d = (p_state_d != P_HUNT) || (hdr_cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q    <= P_HUNT;
            hdr_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            u_out_q      <= '0;
            load_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            idle_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            xsum_q       <= '0;
`endif
        end else begin
            p_state_q    <= p_state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            u_out_q      <= u_out_d;
            load_valid_q <= load_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            idle_cnt_q   <= idle_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            xsum_q       <= xsum_d;
`endif
        end
    end

    assign bus.u_out      = u_out_q;
    assign bus.load_valid = load_valid_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: serial frames are built from random payloads and the
// expected u_out, commit cycle and err cycle are derived from the frame format and bit timing.
`timescale 1ns/1ps
module tb_uart_frame_loader;
    localparam int         DELAY = 15;
    localparam int         P     = DELAY + 1;
    localparam int         HALF  = DELAY / 2;
    localparam int         NC    = 3;
    localparam int         NB    = 4 * NC;
    localparam int         TOB   = 32;
    localparam int         LIMIT = TOB * P;
    localparam logic [7:0] HDR   = 8'h01;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    int            cyc   = 0;
    int            compared   = 0;
    int            mismatched = 0;
    int            lvTimes[$];
    int            errTimes[$];
    logic [32*NC-1:0] uModel;

    uart_frame_loader_if #(.N_CELLS(NC)) bus ();

    uart_frame_loader #(
        .DELAY_FRAMES(DELAY),
        .N_CELLS(NC),
        .HDR_BYTE(HDR),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.load_valid === 1'b1) lvTimes.push_back(cyc);
        if (bus.err === 1'b1) errTimes.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xorSum(input logic [32*NC-1:0] pl);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < NB; k++) s ^= pl[k*8 +: 8];
        return s;
    endfunction

    function automatic logic [32*NC-1:0] randPayload();
        logic [32*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // The line is seen 2 cycles late through the synchronizer; the start bit is sampled HALF+1
    // cycles after detection and the stop bit 9 bit periods after that.
    task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input int gap, output int sampleCyc);
        int c;
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        c = cyc;
        bus.uart_rx = 1'b0;
        repeat (P) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            bus.uart_rx = b[i];
            repeat (P) @(posedge clk);
        end
        #1;
        if (stopOk) begin
            bus.uart_rx = 1'b1;
            repeat (P) @(posedge clk);
        end else begin
            bus.uart_rx = 1'b0;
            repeat (HALF + 4) @(posedge clk);
            #1;
            bus.uart_rx = 1'b1;
            repeat (P - HALF - 4) @(posedge clk);
        end
        sampleCyc = c + 3 + HALF + 9 * P;
    endtask

    task automatic sendFrame(input logic [32*NC-1:0] pl, input logic [7:0] sumFlip, input int maxGap,
                             output int lastS);
        for (int k = 0; k < 4; k++) applyStimulus(HDR, 1'b1, int'($urandom_range(maxGap, 0)), lastS);
        for (int k = 0; k < NB; k++) applyStimulus(pl[k*8 +: 8], 1'b1, int'($urandom_range(maxGap, 0)), lastS);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(xorSum(pl) ^ sumFlip, 1'b1, int'($urandom_range(maxGap, 0)), lastS);
`else
        if (sumFlip != 8'h00) $display("[TB] note: checksum byte not sent in this build");
`endif
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearEvents();
        lvTimes.delete();
        errTimes.delete();
    endtask

    task automatic expectEvents(input string tag, input int nLoad, input int loadCyc, input int nErr, input int errCyc);
        checkOutput({tag, " load count"}, lvTimes.size(), nLoad);
        if (nLoad != 0 && lvTimes.size() != 0) checkOutput({tag, " load cycle"}, lvTimes[0], loadCyc);
        checkOutput({tag, " err count"}, errTimes.size(), nErr);
        if (nErr != 0 && errTimes.size() != 0) checkOutput({tag, " err cycle"}, errTimes[0], errCyc);
    endtask

    task automatic goodFrame(input string tag, input logic [32*NC-1:0] pl, input int maxGap);
        int s;
        clearEvents();
        sendFrame(pl, 8'h00, maxGap, s);
        waitUntil(s + 6);
        expectEvents(tag, 1, s + 2, 0, 0);
        uModel = pl;
        checkOutput({tag, " u_out"}, bus.u_out, uModel);
        checkOutput({tag, " busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [32*NC-1:0] pl;
        logic [7:0]       junk;
        int               s;

        bus.uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset u_out", bus.u_out, '0);
        checkOutput("reset load_valid", bus.load_valid, 1'b0);
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset err", bus.err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        uModel = '0;

        for (int i = 0; i < NC; i++) pl[32*i +: 32] = i * 32'h01010101;
        goodFrame("ramp frame", pl, 0);

`ifdef LOADER_CHECKSUM_EN
        pl = randPayload();
        clearEvents();
        sendFrame(pl, 8'h01, 0, s);
        waitUntil(s + 6);
        expectEvents("bad checksum", 0, 0, 1, s + 2);
        checkOutput("bad checksum u_out", bus.u_out, uModel);
        goodFrame("after bad checksum", pl, 3);
`endif

        clearEvents();
        applyStimulus(HDR, 1'b1, 0, s);
        applyStimulus(HDR, 1'b1, 0, s);
        @(negedge clk);
        checkOutput("hunt busy after 01 01", bus.busy, 1'b1);
        applyStimulus(8'h7F, 1'b1, 0, s);
        pl = randPayload();
        pl[7:0] = HDR;
        goodFrame("hunt five 01s", pl, 0);

        pl = randPayload();
        clearEvents();
        for (int k = 0; k < 4; k++) applyStimulus(HDR, 1'b1, 0, s);
        for (int k = 0; k < 10; k++) applyStimulus(pl[k*8 +: 8], 1'b1, 0, s);
        applyStimulus(pl[87:80], 1'b0, 0, s);
        waitUntil(s + 6);
        expectEvents("framing error", 0, 0, 1, s + 2);
        checkOutput("framing busy", bus.busy, 1'b0);
        checkOutput("framing u_out", bus.u_out, uModel);

        clearEvents();
        for (int k = 0; k < 4; k++) applyStimulus(HDR, 1'b1, 0, s);
        for (int k = 0; k < 6; k++) applyStimulus(pl[k*8 +: 8], 1'b1, 0, s);
        @(negedge clk);
        checkOutput("timeout busy before", bus.busy, 1'b1);
        waitUntil(s + 1 + LIMIT + 4);
        expectEvents("timeout", 0, 0, 1, s + 1 + LIMIT);
        checkOutput("timeout busy after", bus.busy, 1'b0);
        checkOutput("timeout u_out", bus.u_out, uModel);

        clearEvents();
        @(posedge clk);
        #1 bus.uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.uart_rx = 1'b1;
        repeat (2 * P) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch busy", bus.busy, 1'b0);
        goodFrame("after glitch", randPayload(), 0);

        pl = randPayload();
        for (int k = 0; k < 4; k++) applyStimulus(HDR, 1'b1, 0, s);
        for (int k = 0; k < 8; k++) applyStimulus(pl[k*8 +: 8], 1'b1, 0, s);
        @(posedge clk);
        #1 bus.uart_rx = 1'b0;
        repeat (3 * P) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midreset u_out", bus.u_out, '0);
        checkOutput("midreset busy", bus.busy, 1'b0);
        checkOutput("midreset load_valid", bus.load_valid, 1'b0);
        checkOutput("midreset err", bus.err, 1'b0);
        bus.uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        uModel = '0;
        goodFrame("after midreset", randPayload(), 0);

        for (int r = 0; r < 2; r++) begin
            clearEvents();
            for (int j = 0; j < 1 + r; j++) begin
                do junk = 8'($urandom); while (junk == HDR);
                applyStimulus(junk, 1'b1, int'($urandom_range(12, 0)), s);
            end
            goodFrame("random frame", randPayload(), 12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
